// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake head controller: direction and game-state
// encodings, the reversal helper and default grid/tick constants.
package snake_pkg;

    typedef enum logic [1:0] {
        DirUp    = 2'b00,
        DirLeft  = 2'b01,
        DirDown  = 2'b10,
        DirRight = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_t;

    localparam int unsigned GridWDefault   = 16;
    localparam int unsigned GridHDefault   = 16;
    localparam int unsigned TickDivDefault = 6_250_000;

    // Up/down and left/right differ only in bit 1 of the encoding.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry turn buffer. Requests that repeat or reverse the most recent direction
// (tail entry, or ref_dir when empty) are dropped, as are requests when full.
module snake_dir_queue
    import snake_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic push,
    input  dir_t din,
    input  logic pop,
    input  dir_t ref_dir,
    output dir_t dout,
    output logic empty,
    output logic full
);

    dir_t       slot0;
    dir_t       slot1;
    logic [1:0] count;
    dir_t       tail_ref;
    logic       accept;
    logic       do_pop;

    always_comb begin
        tail_ref = ref_dir;
        if (count == 2'd1) begin
            tail_ref = slot0;
        end else if (count == 2'd2) begin
            tail_ref = slot1;
        end
    end

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign dout   = slot0;
    assign do_pop = pop && !empty;
    // The filter always looks at the pre-pop tail, even when a pop lands on the same edge.
    assign accept = push && !full && (din != tail_ref) && (din != opposite(tail_ref));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            slot0 <= DirUp;
            slot1 <= DirUp;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            unique case ({do_pop, accept})
                2'b10: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    count <= count + 2'd1;
                end
                // Only reachable with one entry: it leaves, the new one takes its place.
                2'b11: begin
                    slot0 <= din;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/snake_motion_ctrl.sv
// Snake head game-tick scheduler: run/pause/over FSM, tick counter and head motion.
// Define SNAKE_WRAP_EN to wrap at the grid edges instead of ending the game there.
module snake_motion_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W   = GridWDefault,
    parameter int unsigned GRID_H   = GridHDefault,
    parameter int unsigned TICK_DIV = TickDivDefault
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      dir_valid,
    input  logic [1:0]                dir_in,
    input  logic                      collide,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic [1:0]                cur_dir,
    output logic                      step,
    output logic [1:0]                state
);

    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);
    localparam int unsigned CW = $clog2(TICK_DIV);

    localparam logic [XW-1:0] XMax   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMax   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] XMid   = XW'(GRID_W / 2);
    localparam logic [YW-1:0] YMid   = YW'(GRID_H / 2);
    localparam logic [CW-1:0] CntMax = CW'(TICK_DIV - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] head_x_q;
    logic [YW-1:0] head_y_q;
    dir_t          cur_dir_q;
    logic          step_q;

    logic          q_push;
    logic          q_pop;
    logic          q_clear;
    dir_t          q_dout;
    logic          q_empty;
    logic          q_full;

    logic          tick_go;
    dir_t          new_dir;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          off_grid;
    logic          wall_exit;

    // Collide and pause outrank the tick, so a blocked tick neither pops nor moves.
    assign tick_go = (state_q == StRun) && !collide && !pause && (cnt_q == CntMax);
    assign q_pop   = tick_go && !q_empty;
    assign q_push  = dir_valid && ((state_q == StRun) || (state_q == StPause));
    assign q_clear = start && ((state_q == StIdle) || (state_q == StOver));
    assign new_dir = q_empty ? cur_dir_q : q_dout;

    snake_dir_queue u_dir_queue (
        .clk     (clk),
        .reset   (reset),
        .clear   (q_clear),
        .push    (q_push),
        .din     (dir_t'(dir_in)),
        .pop     (q_pop),
        .ref_dir (cur_dir_q),
        .dout    (q_dout),
        .empty   (q_empty),
        .full    (q_full)
    );

    // Candidate cell one step along new_dir, wrapped at the edges; off_grid flags a wrap.
    always_comb begin
        next_x   = head_x_q;
        next_y   = head_y_q;
        off_grid = 1'b0;
        unique case (new_dir)
            DirUp: begin
                if (head_y_q == '0) begin
                    off_grid = 1'b1;
                    next_y   = YMax;
                end else begin
                    next_y = head_y_q - YW'(1);
                end
            end
            DirDown: begin
                if (head_y_q == YMax) begin
                    off_grid = 1'b1;
                    next_y   = '0;
                end else begin
                    next_y = head_y_q + YW'(1);
                end
            end
            DirLeft: begin
                if (head_x_q == '0) begin
                    off_grid = 1'b1;
                    next_x   = XMax;
                end else begin
                    next_x = head_x_q - XW'(1);
                end
            end
            DirRight: begin
                if (head_x_q == XMax) begin
                    off_grid = 1'b1;
                    next_x   = '0;
                end else begin
                    next_x = head_x_q + XW'(1);
                end
            end
            default: begin
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_exit = 1'b0;
`else
    assign wall_exit = off_grid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            head_x_q  <= XMid;
            head_y_q  <= YMid;
            cur_dir_q <= DirUp;
            step_q    <= 1'b0;
        end else begin
            step_q <= 1'b0;
            unique case (state_q)
                StIdle, StOver: begin
                    if (start) begin
                        state_q   <= StRun;
                        cnt_q     <= '0;
                        head_x_q  <= XMid;
                        head_y_q  <= YMid;
                        cur_dir_q <= DirUp;
                    end
                end
                StRun: begin
                    if (collide) begin
                        state_q <= StOver;
                        cnt_q   <= '0;
                    end else if (pause) begin
                        state_q <= StPause;
                    end else if (cnt_q == CntMax) begin
                        cnt_q     <= '0;
                        cur_dir_q <= new_dir;
                        if (wall_exit) begin
                            state_q <= StOver;
                        end else begin
                            head_x_q <= next_x;
                            head_y_q <= next_y;
                            step_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                // Counter holds here so the resumed tick lands exactly where it left off.
                StPause: begin
                    if (pause) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign head_x  = head_x_q;
    assign head_y  = head_y_q;
    assign cur_dir = cur_dir_q;
    assign step    = step_q;
    assign state   = state_q;

endmodule

// File: tb/tb_snake_motion_ctrl.sv
// Self-checking bench for snake_motion_ctrl: directed game scenarios followed by random
// stimulus, all compared every cycle against a behavioural game model.
module tb_snake_motion_ctrl;

    localparam int TD = 4;
    localparam int W  = 16;
    localparam int H  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic       collide = 1'b0;
    logic [3:0] head_x;
    logic [3:0] head_y;
    logic [1:0] cur_dir;
    logic       step;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Model: states 0 idle, 1 run, 2 pause, 3 over; directions 0 up, 1 left, 2 down, 3 right.
    int m_state, m_x, m_y, m_dir, m_cnt, m_step;
    int m_q[$];

    always #5 clk = ~clk;

    snake_motion_ctrl #(
        .GRID_W   (W),
        .GRID_H   (H),
        .TICK_DIV (TD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .dir_valid (dir_valid),
        .dir_in    (dir_in),
        .collide   (collide),
        .head_x    (head_x),
        .head_y    (head_y),
        .cur_dir   (cur_dir),
        .step      (step),
        .state     (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dx(input int d);
        return (d == 1) ? -1 : ((d == 3) ? 1 : 0);
    endfunction

    function automatic int dy(input int d);
        return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_x     = W / 2;
        m_y     = H / 2;
        m_dir   = 0;
        m_cnt   = 0;
        m_step  = 0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit pz, input bit dv,
                              input int d, input bit col);
        int  refd;
        int  nx;
        int  ny;
        bit  accept;
        if (rst) begin
            model_reset();
            return;
        end
        m_step = 0;
        refd   = (m_q.size() > 0) ? m_q[m_q.size() - 1] : m_dir;
        accept = (m_state == 1 || m_state == 2) && dv && (m_q.size() < 2)
                 && (d != refd) && (d != (refd ^ 2));
        case (m_state)
            0, 3: begin
                if (st) begin
                    m_state = 1;
                    m_x     = W / 2;
                    m_y     = H / 2;
                    m_dir   = 0;
                    m_cnt   = 0;
                    m_q.delete();
                end
            end
            1: begin
                if (col) begin
                    m_state = 3;
                    m_cnt   = 0;
                end else if (pz) begin
                    m_state = 2;
                end else if (m_cnt == TD - 1) begin
                    m_cnt = 0;
                    if (m_q.size() > 0) m_dir = m_q.pop_front();
                    nx = m_x + dx(m_dir);
                    ny = m_y + dy(m_dir);
                    if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
`ifdef SNAKE_WRAP_EN
                        m_x    = (nx + W) % W;
                        m_y    = (ny + H) % H;
                        m_step = 1;
`else
                        m_state = 3;
`endif
                    end else begin
                        m_x    = nx;
                        m_y    = ny;
                        m_step = 1;
                    end
                end else begin
                    m_cnt++;
                end
            end
            2: begin
                if (pz) m_state = 1;
            end
            default: begin
            end
        endcase
        if (accept) m_q.push_back(d);
    endtask

    task automatic cyc(input bit rst, input bit st, input bit pz, input bit dv, input int d,
                       input bit col);
        reset     = rst;
        start     = st;
        pause     = pz;
        dir_valid = dv;
        dir_in    = 2'(d);
        collide   = col;
        model_edge(rst, st, pz, dv, d, col);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        dir_valid = 1'b0;
        collide   = 1'b0;
        chk("state", state, m_state);
        chk("head_x", head_x, m_x);
        chk("head_y", head_y, m_y);
        chk("cur_dir", cur_dir, m_dir);
        chk("step", step, m_step);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic dirv(input int d);
        cyc(0, 0, 0, 1, d, 0);
    endtask

    initial begin
        // Reset values
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_state", state, 0);
        chk("rst_x", head_x, 8);
        chk("rst_y", head_y, 8);
        chk("rst_step", step, 0);

        // Start and first step after TD cycles
        cyc(0, 1, 0, 0, 0, 0);
        chk("start_state", state, 1);
        chk("start_xy", {head_x, head_y}, {4'd8, 4'd8});
        run(3);
        chk("first_step_early", step, 0);
        run(1);
        chk("first_step", step, 1);
        chk("first_step_y", head_y, 7);
        chk("first_step_dir", cur_dir, 0);

        // Reversal and duplicate dropped
        dirv(2);
        dirv(0);
        run(2);
        chk("rev_dup_xy", {head_x, head_y}, {4'd8, 4'd6});

        // Two queued turns applied on consecutive ticks
        dirv(1);
        dirv(2);
        run(2);
        chk("turn1_xy", {head_x, head_y}, {4'd7, 4'd6});
        chk("turn1_dir", cur_dir, 1);
        run(4);
        chk("turn2_xy", {head_x, head_y}, {4'd7, 4'd7});
        chk("turn2_dir", cur_dir, 2);

        // Third turn dropped when the queue is full
        dirv(1);
        dirv(2);
        dirv(3);
        run(1);
        chk("full1_xy", {head_x, head_y}, {4'd6, 4'd7});
        run(4);
        chk("full2_xy", {head_x, head_y}, {4'd6, 4'd8});
        run(4);
        chk("full3_xy", {head_x, head_y}, {4'd6, 4'd9});
        chk("full3_dir", cur_dir, 2);

        // Pause at counter 2, resume, step two cycles later
        run(2);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pause_state", state, 2);
        for (int i = 0; i < 10; i++) begin
            run(1);
            chk("pause_no_step", step, 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("resume_state", state, 1);
        run(1);
        chk("resume_early", step, 0);
        run(1);
        chk("resume_step", step, 1);
        chk("resume_xy", {head_x, head_y}, {4'd6, 4'd10});

        // Collide on terminal count, restart clears the queue
        run(2);
        dirv(1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("collide_state", state, 3);
        chk("collide_xy", {head_x, head_y}, {4'd6, 4'd10});
        chk("collide_step", step, 0);
        dirv(3);
        cyc(0, 1, 0, 0, 0, 0);
        chk("restart_xy", {head_x, head_y}, {4'd8, 4'd8});
        run(4);
        chk("restart_step_xy", {head_x, head_y}, {4'd8, 4'd7});
        chk("restart_dir", cur_dir, 0);

        // Walk left to the wall, then one more step
        dirv(1);
        run(3);
        chk("walk_x", head_x, 7);
        run(28);
        chk("wall_x", head_x, 0);
        run(4);
`ifdef SNAKE_WRAP_EN
        chk("wrap_x", head_x, 15);
        chk("wrap_step", step, 1);
        chk("wrap_state", state, 1);
`else
        chk("wall_state", state, 3);
        chk("wall_hold_x", head_x, 0);
        chk("wall_step", step, 0);
`endif

        // Mid-game reset
        cyc(0, 1, 0, 0, 0, 0);
        run(5);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midrst_state", state, 0);
        chk("midrst_xy", {head_x, head_y}, {4'd8, 4'd8});
        chk("midrst_dir", cur_dir, 0);

        // Random play
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(499) == 0, $urandom_range(19) == 0, $urandom_range(24) == 0,
                $urandom_range(2) == 0, int'($urandom_range(3)), $urandom_range(149) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
